wb_pipe_ctrl: RTL and testbench



---
 rtl/wb_pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_wb_pipe_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_ctrl.sv
// Register-write intent pipeline (EX -> MEM -> WB), forwarding ports, load-data merge and load-use hazard.
// Optional WB_PERF_CNT_EN adds WB-write and load-use-stall event counters.
module wb_pipe_ctrl #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ex_valid,
    input  logic          ex_we_i,
    input  logic [AW-1:0] ex_waddr_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic          ex_is_load,
    input  logic          mem_stall,
    input  logic          wb_stall,
    input  logic          flush,
    input  logic [DW-1:0] dram_rdata,
    input  logic [AW-1:0] id_raddr1,
    input  logic [AW-1:0] id_raddr2,
    output logic          ex_we,
    output logic [AW-1:0] ex_waddr,
    output logic [DW-1:0] ex_wdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          wb_we,
    output logic [AW-1:0] wb_waddr,
    output logic [DW-1:0] wb_wdata,
    output logic          load_use_stall
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_wb_writes,
    output logic [31:0]   perf_lu_stalls
`endif
);

    logic          mem_we_q, mem_we_d;
    logic          mem_is_load_q, mem_is_load_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          wb_we_q, wb_we_d;
    logic          wb_is_load_q, wb_is_load_d;
    logic [AW-1:0] wb_waddr_q, wb_waddr_d;
    logic [DW-1:0] wb_wdata_q, wb_wdata_d;
    logic          wb_done_q, wb_done_d;
    logic          haz1, haz2;

    always_comb begin
        mem_we_d      = mem_we_q;
        mem_is_load_d = mem_is_load_q;
        mem_waddr_d   = mem_waddr_q;
        mem_wdata_d   = mem_wdata_q;
        if (flush) begin
            mem_we_d      = 1'b0;
            mem_is_load_d = 1'b0;
        end else if (!mem_stall) begin
            mem_we_d      = ex_valid & ex_we_i & (ex_waddr_i != '0);
            mem_is_load_d = ex_valid & ex_is_load;
            mem_waddr_d   = ex_waddr_i;
            mem_wdata_d   = ex_wdata_i;
        end

        // While WB is frozen its write has already been presented once; remember that.
        wb_we_d      = wb_we_q;
        wb_is_load_d = wb_is_load_q;
        wb_waddr_d   = wb_waddr_q;
        wb_wdata_d   = wb_wdata_q;
        wb_done_d    = wb_done_q | wb_we_q;
        if (!wb_stall) begin
            wb_done_d = 1'b0;
            if (flush || mem_stall) begin
                wb_we_d      = 1'b0;
                wb_is_load_d = 1'b0;
            end else begin
                wb_we_d      = mem_we_q;
                wb_is_load_d = mem_is_load_q;
                wb_waddr_d   = mem_waddr_q;
                wb_wdata_d   = mem_wdata_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_we_q      <= 1'b0;
            mem_is_load_q <= 1'b0;
            mem_waddr_q   <= '0;
            mem_wdata_q   <= '0;
            wb_we_q       <= 1'b0;
            wb_is_load_q  <= 1'b0;
            wb_waddr_q    <= '0;
            wb_wdata_q    <= '0;
            wb_done_q     <= 1'b0;
        end else begin
            mem_we_q      <= mem_we_d;
            mem_is_load_q <= mem_is_load_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_we_q       <= wb_we_d;
            wb_is_load_q  <= wb_is_load_d;
            wb_waddr_q    <= wb_waddr_d;
            wb_wdata_q    <= wb_wdata_d;
            wb_done_q     <= wb_done_d;
        end
    end

    assign ex_we     = ex_valid & ex_we_i & ~ex_is_load & (ex_waddr_i != '0);
    assign ex_waddr  = ex_waddr_i;
    assign ex_wdata  = ex_wdata_i;

    // Load data only exists from WB onward, so MEM never forwards a load.
    assign mem_we    = mem_we_q & ~mem_is_load_q & (mem_waddr_q != '0);
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;

    assign wb_we     = wb_we_q & ~wb_done_q & (wb_waddr_q != '0);
    assign wb_waddr  = wb_waddr_q;
    assign wb_wdata  = wb_is_load_q ? dram_rdata : wb_wdata_q;

    assign haz1 = (id_raddr1 != '0) &
                  ((ex_valid & ex_we_i & ex_is_load & (id_raddr1 == ex_waddr_i)) |
                   (mem_we_q & mem_is_load_q & (id_raddr1 == mem_waddr_q)));
    assign haz2 = (id_raddr2 != '0) &
                  ((ex_valid & ex_we_i & ex_is_load & (id_raddr2 == ex_waddr_i)) |
                   (mem_we_q & mem_is_load_q & (id_raddr2 == mem_waddr_q)));
    assign load_use_stall = haz1 | haz2;

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_wb_writes <= '0;
            perf_lu_stalls <= '0;
        end else begin
            if (wb_we)          perf_wb_writes <= perf_wb_writes + 32'd1;
            if (load_use_stall) perf_lu_stalls <= perf_lu_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_pipe_ctrl.sv
// Bench for wb_pipe_ctrl: directed scenarios plus random traffic against an instruction-slot model.
module tb_wb_pipe_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ex_valid, ex_we_i, ex_is_load, mem_stall, wb_stall, flush;
    logic [AW-1:0] ex_waddr_i, id_raddr1, id_raddr2;
    logic [DW-1:0] ex_wdata_i, dram_rdata;
    logic          ex_we, mem_we, wb_we, load_use_stall;
    logic [AW-1:0] ex_waddr, mem_waddr, wb_waddr;
    logic [DW-1:0] ex_wdata, mem_wdata, wb_wdata;
`ifdef WB_PERF_CNT_EN
    logic [31:0]   perf_wb_writes, perf_lu_stalls;
    logic [31:0]   m_cnt_wr, m_cnt_lu;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_pipe_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i),
        .ex_wdata_i(ex_wdata_i), .ex_is_load(ex_is_load),
        .mem_stall(mem_stall), .wb_stall(wb_stall), .flush(flush),
        .dram_rdata(dram_rdata), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .load_use_stall(load_use_stall)
`ifdef WB_PERF_CNT_EN
        , .perf_wb_writes(perf_wb_writes), .perf_lu_stalls(perf_lu_stalls)
`endif
    );

    // One instruction slot: its write intent, and whether WB already retired it.
    typedef struct {
        bit        we;
        bit        ld;
        bit [4:0]  a;
        bit [31:0] d;
        bit        done;
    } slot_t;

    slot_t m_mem, m_wb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit hazard(input bit [4:0] r);
        bit ex_hit, mem_hit;
        ex_hit  = ex_valid && ex_we_i && ex_is_load && (r == ex_waddr_i);
        mem_hit = m_mem.we && m_mem.ld && (r == m_mem.a);
        return (r != 0) && (ex_hit || mem_hit);
    endfunction

    function automatic bit exp_stall();
        return hazard(id_raddr1) || hazard(id_raddr2);
    endfunction

    function automatic bit exp_mem_we();
        return m_mem.we && !m_mem.ld && (m_mem.a != 0);
    endfunction

    function automatic bit exp_wb_we();
        return m_wb.we && (m_wb.a != 0) && !m_wb.done;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mem = '{default: 0};
            m_wb  = '{default: 0};
`ifdef WB_PERF_CNT_EN
            m_cnt_wr = 0;
            m_cnt_lu = 0;
`endif
        end else begin
`ifdef WB_PERF_CNT_EN
            if (exp_wb_we()) m_cnt_wr = m_cnt_wr + 1;
            if (exp_stall()) m_cnt_lu = m_cnt_lu + 1;
`endif
            if (wb_stall)
                m_wb.done = 1;
            else if (flush || mem_stall)
                m_wb = '{default: 0};
            else begin
                m_wb = m_mem;
                m_wb.done = 0;
            end
            if (flush)
                m_mem = '{default: 0};
            else if (!mem_stall)
                m_mem = '{we: ex_valid && ex_we_i, ld: ex_valid && ex_is_load,
                          a: ex_waddr_i, d: ex_wdata_i, done: 0};
        end
    end

    task automatic check_model();
        bit exp_ex_we;
        exp_ex_we = ex_valid && ex_we_i && !ex_is_load && (ex_waddr_i != 0);
        chk("ex_we", ex_we, exp_ex_we);
        chk("ex_waddr", ex_waddr, ex_waddr_i);
        chk("ex_wdata", ex_wdata, ex_wdata_i);
        chk("mem_we", mem_we, exp_mem_we());
        if (exp_mem_we()) begin
            chk("mem_waddr", mem_waddr, m_mem.a);
            chk("mem_wdata", mem_wdata, m_mem.d);
        end
        chk("wb_we", wb_we, exp_wb_we());
        if (exp_wb_we()) begin
            chk("wb_waddr", wb_waddr, m_wb.a);
            chk("wb_wdata", wb_wdata, m_wb.ld ? dram_rdata : m_wb.d);
        end
        chk("load_use_stall", load_use_stall, exp_stall());
`ifdef WB_PERF_CNT_EN
        chk("perf_wb_writes", perf_wb_writes, m_cnt_wr);
        chk("perf_lu_stalls", perf_lu_stalls, m_cnt_lu);
`endif
    endtask

    // Drive one cycle of inputs mid-cycle, then compare against the model.
    task automatic cyc(input bit v, input bit we, input bit [4:0] a, input bit [31:0] d,
                       input bit ld, input bit ms, input bit ws, input bit fl,
                       input bit [4:0] r1, input bit [4:0] r2, input bit [31:0] dr);
        @(negedge clk);
        ex_valid = v; ex_we_i = we; ex_waddr_i = a; ex_wdata_i = d; ex_is_load = ld;
        mem_stall = ms; wb_stall = ws; flush = fl;
        id_raddr1 = r1; id_raddr2 = r2; dram_rdata = dr;
        #1;
        check_model();
    endtask

    task automatic idle(input bit ms = 0, input bit ws = 0, input bit fl = 0);
        cyc(0, 0, 0, 0, 0, ms, ws, fl, 0, 0, 32'hDEAD_0000);
    endtask

    initial begin
        resetn = 1'b0;
        ex_valid = 0; ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0; ex_is_load = 0;
        mem_stall = 0; wb_stall = 0; flush = 0; id_raddr1 = 0; id_raddr2 = 0; dram_rdata = 0;
        #12;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_wb_wdata", wb_wdata, 0);
        chk("rst_stall", load_use_stall, 0);
        @(negedge clk);
        resetn = 1'b1;

        // ALU write, two-cycle latency to WB
        cyc(1, 1, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_ex_we", ex_we, 1);
        idle();
        chk("alu_mem_we", mem_we, 1);
        chk("alu_mem_waddr", mem_waddr, 3);
        chk("alu_mem_wdata", mem_wdata, 32'h1234);
        idle();
        chk("alu_wb_we", wb_we, 1);
        chk("alu_wb_waddr", wb_waddr, 3);
        chk("alu_wb_wdata", wb_wdata, 32'h1234);
        idle();
        chk("alu_wb_once", wb_we, 0);

        // Load-use on r5
        cyc(1, 1, 5, 32'h0, 1, 0, 0, 0, 5, 0, 0);
        chk("lu_ex_stall", load_use_stall, 1);
        chk("lu_ex_we", ex_we, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        chk("lu_mem_stall", load_use_stall, 1);
        chk("lu_mem_we", mem_we, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hCAFE);
        chk("lu_wb_stall", load_use_stall, 0);
        chk("lu_wb_we", wb_we, 1);
        chk("lu_wb_wdata", wb_wdata, 32'hCAFE);

        // r0 writes and r0 loads are inert
        cyc(1, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_ex_we", ex_we, 0);
        idle();
        chk("r0_mem_we", mem_we, 0);
        idle();
        chk("r0_wb_we", wb_we, 0);
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("r0_stall", load_use_stall, 0);

        // Flush kills r7 sitting in MEM
        cyc(1, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 1);
        chk("fl_mem_we", mem_we, 1);
        idle();
        chk("fl_wb_we1", wb_we, 0);
        chk("fl_mem_we_after", mem_we, 0);
        idle();
        chk("fl_wb_we2", wb_we, 0);

        // MEM stall holds r9, WB gets bubbles, r9 retires once
        cyc(1, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        chk("st_mem_waddr", mem_waddr, 9);
        idle(1, 0, 0);
        chk("st_mem_we", mem_we, 1);
        chk("st_wb_bubble", wb_we, 0);
        idle();
        chk("st_wb_bubble2", wb_we, 0);
        idle();
        chk("st_wb_we", wb_we, 1);
        chk("st_wb_waddr", wb_waddr, 9);
        idle();
        chk("st_wb_once", wb_we, 0);

        // WB stall must not repeat a write
        cyc(1, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle(1, 1, 0);
        chk("ws_wb_we", wb_we, 1);
        idle(1, 1, 0);
        chk("ws_no_repeat", wb_we, 0);
        idle();
        chk("ws_no_repeat2", wb_we, 0);

        // Asynchronous reset with a write in WB
        cyc(1, 1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        chk("ar_wb_we_before", wb_we, 1);
        resetn = 1'b0;
        #1;
        chk("ar_wb_we_async", wb_we, 0);
        chk("ar_mem_we_async", mem_we, 0);
`ifdef WB_PERF_CNT_EN
        chk("ar_perf_wr", perf_wb_writes, 0);
        chk("ar_perf_lu", perf_lu_stalls, 0);
`endif
        @(negedge clk);
        resetn = 1'b1;

        // Random traffic; WB stall only ever accompanies a MEM stall
        for (int i = 0; i < 3000; i++) begin
            bit ms, ws;
            ms = ($urandom_range(0, 3) == 0);
            ws = ms && ($urandom_range(0, 1) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
                ms, ws, $urandom_range(0, 9) == 0,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
